fht_twiddle_seq: RTL and testbench
==================================

Name: fht_twiddle_seq

Overview:
Twiddle-factor requester for the FHT butterfly datapath. It is the initiator that drives the twiddle ROM block: for a requested stage it walks every twiddle index k, issues ROM addresses, and selects the pair-0 (0..pi/2) or pair-1 (pi/2..pi) sin/cos outputs. It absorbs the 1-cycle ROM read latency and delivers coefficients to the butterfly over a valid/ready stream with a 2-entry skid buffer.

Parameters:
W_BIT, 12, coefficient width (signed), matches ROM word width
A_BIT, 8, ROM address width; ROM holds a quarter period in 2^A_BIT entries
S_BIT, 4, width of stage number input

Ports:
iCLK  in  1  clock
iRESET  in  1  synchronous active-low reset
iSTART  in  1  start-of-stage request pulse
iSTAGE  in  S_BIT  stage number s
oROM_ADDR  out  A_BIT  address to twiddle ROM
iROM_SIN_0  in  W_BIT  ROM sin, quadrant 0
iROM_COS_0  in  W_BIT  ROM cos, quadrant 0
iROM_SIN_1  in  W_BIT  ROM sin, quadrant 1
iROM_COS_1  in  W_BIT  ROM cos, quadrant 1
oSIN  out  W_BIT  coefficient sin
oCOS  out  W_BIT  coefficient cos
oK  out  A_BIT+1  twiddle index of current coefficient
oLAST  out  1  current coefficient is last of stage
oVALID  out  1  coefficient valid
iREADY  in  1  butterfly accepts coefficient
oBUSY  out  1  stage in progress
oDONE  out  1  one-cycle pulse, stage finished
oERR  out  1  one-cycle pulse, illegal stage rejected

Behaviour:
- One clock; reset is synchronous and active-low (iRESET low at a rising iCLK edge resets). All outputs 0 in reset; FSM to IDLE; skid buffer emptied; in-flight ROM read discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: iSTART=1 with s <= A_BIT+1 -> latch s, k=0, ISSUE, oBUSY=1 next cycle. s > A_BIT+1 -> oERR pulse next cycle, stay IDLE. iSTART outside IDLE ignored.
- Stage s has N = 2^s twiddles, k = 0..N-1, angle pi*k/2^s.
- Half-circle index h = k << (A_BIT+1-s), A_BIT+1 bits. oROM_ADDR = h[A_BIT-1:0] (registered); select bit q = h[A_BIT], delayed 1 cycle to align with ROM data. q=0 -> {SIN_0,COS_0}; q=1 -> {SIN_1,COS_1}. Data passed through unmodified.
- ROM model: address sampled at edge E, q valid after E, captured into skid buffer at E+1.
- Issue rule (ISSUE): new address issued in a cycle iff count + inflight - pop < 2, where count = skid entries, inflight = read issued previous cycle, pop = oVALID & iREADY. k increments per issue; issuing k=N-1 -> DRAIN.
- DRAIN: when skid empty and nothing in flight -> oDONE pulse 1 cycle, oBUSY=0, IDLE. oDONE coincides with the cycle after the final handshake.
- Skid buffer: 2-entry FIFO of {sin, cos, k, last}; oVALID = count!=0; head held stable while oVALID & !iREADY. Never overflows by the issue rule.
- Latency: iSTART sampled at edge T; first oVALID after edge T+3. With iREADY held 1, one coefficient per cycle, stage of N takes N+3 cycles to oDONE.
- Stage 0: single k=0, h=0. Stage A_BIT+1: shift 0, all 2^(A_BIT+1) entries.
- Back-to-back: iSTART accepted in the cycle IDLE is entered after oDONE.

Test Plan:
- Reset then s=2, iREADY=1 -> oROM_ADDR 0,128,0,128; q 0,0,1,1; oK 0..3 with pair-0 data for k=0,1, pair-1 for k=2,3; oLAST on k=3; first oVALID 3 edges after iSTART; oDONE 1 cycle after k=3 handshake.
- s=0 -> exactly one coefficient k=0, ROM addr 0, pair 0, oLAST=1, oDONE follows.
- s=9 (A_BIT+1), iREADY=1 -> 512 coefficients, addresses 0..255 twice, no gaps, oDONE at edge 515 after start.
- s=3 with iREADY toggling randomly and held low 5 cycles mid-stage -> all 8 coefficients delivered once, in order, head stable while stalled, no loss/duplication.
- s=10 -> oERR pulse, oBUSY stays 0, no ROM addresses change, no oVALID; iSTART during a running stage ignored.
- Reset asserted mid s=4 stage with 2 entries buffered -> next cycle all outputs 0, IDLE; new s=1 start gives clean k=0,1 only.

Source files
------------

// File: rtl/fht_twiddle_seq.sv
// fht_twiddle_seq: twiddle-factor requester for the FHT butterfly datapath.
// For a requested stage it walks every twiddle index k, drives the twiddle
// ROM address, selects the quadrant-0 or quadrant-1 sin/cos pair once the
// registered ROM data arrives, and hands coefficients to the butterfly over
// a valid/ready stream backed by a 2-entry skid buffer.
//
// The ROM address register is loaded one cycle ahead of its request. An
// address counts as issued in the cycle it sits on oROM_ADDR, so the ROM
// samples it at the end of that same cycle. One setup cycle after start
// loads the first address. With this arrangement only one ROM read is ever
// in flight, and the credit check (count + inflight - pop < 2) cannot
// overflow the buffer while still sustaining one coefficient per cycle.
module fht_twiddle_seq #(
  parameter int W_BIT = 12,
  parameter int A_BIT = 8,
  parameter int S_BIT = 4
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic [S_BIT-1:0] iSTAGE,
  output logic [A_BIT-1:0] oROM_ADDR,
  input  logic [W_BIT-1:0] iROM_SIN_0,
  input  logic [W_BIT-1:0] iROM_COS_0,
  input  logic [W_BIT-1:0] iROM_SIN_1,
  input  logic [W_BIT-1:0] iROM_COS_1,
  output logic [W_BIT-1:0] oSIN,
  output logic [W_BIT-1:0] oCOS,
  output logic [A_BIT:0]   oK,
  output logic             oLAST,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  localparam int H_BIT = A_BIT + 1;
  localparam logic [S_BIT-1:0] MAX_STAGE = S_BIT'(H_BIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_reg;
  logic [S_BIT-1:0]   stage_reg;
  logic [H_BIT-1:0]   k_reg;
  logic               addr_ok_reg;   // oROM_ADDR currently holds h(k_reg)
  logic [A_BIT-1:0]   addr_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  // ROM read in flight: data appears on the ROM outputs this cycle
  logic               fly_reg;
  logic               fly_q_reg;
  logic               fly_last_reg;
  logic [H_BIT-1:0]   fly_k_reg;

  // Skid buffer, entry 0 is always the head
  logic [W_BIT-1:0]   sin_mem [2];
  logic [W_BIT-1:0]   cos_mem [2];
  logic [H_BIT-1:0]   k_mem   [2];
  logic               last_mem[2];
  logic [1:0]         count_reg;

  logic [S_BIT-1:0]   sh_amt;
  logic [H_BIT-1:0]   k_inc;
  logic [H_BIT-1:0]   h_cur;
  logic [H_BIT-1:0]   h_next;
  logic [H_BIT-1:0]   k_mask;
  logic               last_k;
  logic               pop;
  logic [1:0]         count_next;
  logic               issue;
  logic               wr_idx;
  logic [W_BIT-1:0]   rom_sin;
  logic [W_BIT-1:0]   rom_cos;

  // Index arithmetic, handshake and credit check for the current cycle
  always_comb begin
    sh_amt     = MAX_STAGE - stage_reg;
    k_inc      = k_reg + H_BIT'(1);
    h_cur      = k_reg << sh_amt;
    h_next     = k_inc << sh_amt;
    k_mask     = {H_BIT{1'b1}} >> sh_amt;
    last_k     = (k_reg == k_mask);
    pop        = (count_reg != 2'd0) && iREADY;
    count_next = count_reg + {1'b0, fly_reg} - {1'b0, pop};
    issue      = (state_reg == ISSUE) && addr_ok_reg && (count_next < 2'd2);
    // Incoming entry lands behind whatever survives this cycle's pop
    wr_idx     = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop);
    rom_sin    = fly_q_reg ? iROM_SIN_1 : iROM_SIN_0;
    rom_cos    = fly_q_reg ? iROM_COS_1 : iROM_COS_0;
  end

  // Control FSM: stage acceptance, address walk, in-flight tracking, status pulses
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_reg    <= IDLE;
      stage_reg    <= '0;
      k_reg        <= '0;
      addr_ok_reg  <= 1'b0;
      addr_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      fly_reg      <= 1'b0;
      fly_q_reg    <= 1'b0;
      fly_last_reg <= 1'b0;
      fly_k_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      fly_reg  <= issue;
      if (issue) begin
        fly_q_reg    <= h_cur[A_BIT];
        fly_last_reg <= last_k;
        fly_k_reg    <= k_reg;
      end
      case (state_reg)
        IDLE: begin
          if (iSTART) begin
            if (iSTAGE <= MAX_STAGE) begin
              stage_reg   <= iSTAGE;
              k_reg       <= '0;
              addr_ok_reg <= 1'b0;
              busy_reg    <= 1'b1;
              state_reg   <= ISSUE;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!addr_ok_reg) begin
            addr_reg    <= h_cur[A_BIT-1:0];
            addr_ok_reg <= 1'b1;
          end else if (issue) begin
            if (last_k) begin
              state_reg <= DRAIN;
            end else begin
              k_reg    <= k_inc;
              addr_reg <= h_next[A_BIT-1:0];
            end
          end
        end
        DRAIN: begin
          if ((count_next == 2'd0) && !fly_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Skid buffer: shift on pop, capture ROM data arriving this cycle
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        sin_mem[i]  <= '0;
        cos_mem[i]  <= '0;
        k_mem[i]    <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      count_reg <= count_next;
      if (pop) begin
        sin_mem[0]  <= sin_mem[1];
        cos_mem[0]  <= cos_mem[1];
        k_mem[0]    <= k_mem[1];
        last_mem[0] <= last_mem[1];
      end
      if (fly_reg) begin
        sin_mem[wr_idx]  <= rom_sin;
        cos_mem[wr_idx]  <= rom_cos;
        k_mem[wr_idx]    <= fly_k_reg;
        last_mem[wr_idx] <= fly_last_reg;
      end
    end
  end

  assign oROM_ADDR = addr_reg;
  assign oSIN      = sin_mem[0];
  assign oCOS      = cos_mem[0];
  assign oK        = k_mem[0];
  assign oLAST     = last_mem[0];
  assign oVALID    = (count_reg != 2'd0);
  assign oBUSY     = busy_reg;
  assign oDONE     = done_reg;
  assign oERR      = err_reg;

endmodule

// File: tb/tb_fht_twiddle_seq.sv
// tb_fht_twiddle_seq: directed bench for the twiddle requester. A registered
// ROM model encodes quadrant and address into every word so each delivered
// coefficient identifies exactly which ROM location and pair it came from.
module tb_fht_twiddle_seq;

  logic        iCLK;
  logic        iRESET;
  logic        iSTART;
  logic [3:0]  iSTAGE;
  logic [7:0]  oROM_ADDR;
  logic [11:0] rom_sin0, rom_cos0, rom_sin1, rom_cos1;
  logic [11:0] oSIN, oCOS;
  logic [8:0]  oK;
  logic        oLAST, oVALID, iREADY, oBUSY, oDONE, oERR;

  logic [7:0]  rom_addr_q;

  int checks;
  int errors;

  typedef struct {
    int stage;
    int mode;       // 0: ready held 1, 1: random ready with a 5-cycle low window
    int inject;     // 1: pulse iSTART mid-stage (must be ignored)
    int exp_n;
    int exp_first;
    int exp_done;   // 0: not checked
  } vec_t;

  vec_t vecs[6];

  fht_twiddle_seq #(.W_BIT(12), .A_BIT(8), .S_BIT(4)) dut (
    .iCLK       (iCLK),
    .iRESET     (iRESET),
    .iSTART     (iSTART),
    .iSTAGE     (iSTAGE),
    .oROM_ADDR  (oROM_ADDR),
    .iROM_SIN_0 (rom_sin0),
    .iROM_COS_0 (rom_cos0),
    .iROM_SIN_1 (rom_sin1),
    .iROM_COS_1 (rom_cos1),
    .oSIN       (oSIN),
    .oCOS       (oCOS),
    .oK         (oK),
    .oLAST      (oLAST),
    .oVALID     (oVALID),
    .iREADY     (iREADY),
    .oBUSY      (oBUSY),
    .oDONE      (oDONE),
    .oERR       (oERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Registered ROM: address sampled on the edge, data valid after it
  always @(posedge iCLK) rom_addr_q <= oROM_ADDR;
  assign rom_sin0 = {4'h1, rom_addr_q};
  assign rom_cos0 = {4'h2, rom_addr_q};
  assign rom_sin1 = {4'h3, rom_addr_q};
  assign rom_cos1 = {4'h4, rom_addr_q};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_word(input int s, input int k, input bit is_cos);
    int h;
    logic [8:0] hv;
    h  = (k << (9 - s)) & 511;
    hv = 9'(h);
    if (hv[8]) return is_cos ? {4'h4, hv[7:0]} : {4'h3, hv[7:0]};
    else       return is_cos ? {4'h2, hv[7:0]} : {4'h1, hv[7:0]};
  endfunction

  function automatic bit pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c >= 6 && c <= 10) return 1'b0;
    if (c < 30) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic reset_outputs(input string tag);
    check({tag, "_addr"},  64'(oROM_ADDR), 64'd0);
    check({tag, "_sin"},   64'(oSIN),      64'd0);
    check({tag, "_cos"},   64'(oCOS),      64'd0);
    check({tag, "_k"},     64'(oK),        64'd0);
    check({tag, "_last"},  64'(oLAST),     64'd0);
    check({tag, "_valid"}, 64'(oVALID),    64'd0);
    check({tag, "_busy"},  64'(oBUSY),     64'd0);
    check({tag, "_done"},  64'(oDONE),     64'd0);
    check({tag, "_err"},   64'(oERR),      64'd0);
  endtask

  task automatic start_stage(input int s);
    @(negedge iCLK);
    iSTART = 1'b1;
    iSTAGE = 4'(s);
    @(posedge iCLK);
    #1;
    iSTART = 1'b0;
  endtask

  // Called right after the start edge; c counts edges since that edge
  task automatic collect(input int s, input int mode, input int inject, input int exp_n,
                         input int exp_first, input int exp_done, input int chain_s);
    int idx;
    int first;
    int c;
    bit done_seen;
    bit hold;
    bit rdy;
    logic [33:0] prev_head;
    idx = 0; first = -1; c = 0; done_seen = 1'b0; hold = 1'b0; prev_head = '0;
    while (!done_seen && c < 3000) begin
      @(negedge iCLK);
      rdy = pick_ready(mode, c);
      iREADY = rdy;
      if (inject != 0 && c == 2) begin iSTART = 1'b1; iSTAGE = 4'd5; end
      if (inject != 0 && c == 3) iSTART = 1'b0;
      if (c == 0) check($sformatf("s%0d_busy_after_start", s), 64'(oBUSY), 64'd1);
      if (hold)
        check($sformatf("s%0d_stall_head_c%0d", s, c), {30'd0, oVALID, oSIN, oCOS, oK, oLAST},
              {30'd0, 1'b1, prev_head});
      if (oVALID && first < 0) first = c;
      if (oVALID && rdy) begin
        if (idx < exp_n) begin
          check($sformatf("s%0d_k%0d_k", s, idx),   64'(oK),   64'(idx));
          check($sformatf("s%0d_k%0d_sin", s, idx), 64'(oSIN), 64'(exp_word(s, idx, 1'b0)));
          check($sformatf("s%0d_k%0d_cos", s, idx), 64'(oCOS), 64'(exp_word(s, idx, 1'b1)));
          check($sformatf("s%0d_k%0d_last", s, idx), 64'(oLAST), 64'(idx == exp_n - 1));
        end else begin
          check($sformatf("s%0d_extra_coef", s), 64'(idx), 64'(exp_n - 1));
        end
        idx++;
      end
      hold = oVALID && !rdy;
      prev_head = {oSIN, oCOS, oK, oLAST};
      if (oDONE) begin
        done_seen = 1'b1;
        check($sformatf("s%0d_first_valid", s), 64'(first), 64'(exp_first));
        check($sformatf("s%0d_count", s), 64'(idx), 64'(exp_n));
        if (exp_done > 0) check($sformatf("s%0d_done_cycle", s), 64'(c), 64'(exp_done));
        check($sformatf("s%0d_busy_at_done", s), 64'(oBUSY), 64'd0);
        $display("stage %0d: %0d coefficients, first valid at %0d, done at %0d", s, idx, first, c);
        if (chain_s >= 0) begin
          iSTART = 1'b1;
          iSTAGE = 4'(chain_s);
          @(posedge iCLK);
          #1;
          iSTART = 1'b0;
        end
      end else begin
        c++;
      end
    end
    if (!done_seen) begin
      errors++;
      checks++;
      $display("FAIL s%0d_timeout: got no oDONE expected oDONE within 3000 cycles", s);
    end
  endtask

  initial begin
    logic [7:0] addr_before;
    checks = 0;
    errors = 0;
    iRESET = 1'b0;
    iSTART = 1'b0;
    iSTAGE = 4'd0;
    iREADY = 1'b0;

    vecs[0] = '{stage: 2, mode: 0, inject: 0, exp_n: 4,   exp_first: 3, exp_done: 7};
    vecs[1] = '{stage: 0, mode: 0, inject: 0, exp_n: 1,   exp_first: 3, exp_done: 4};
    vecs[2] = '{stage: 3, mode: 1, inject: 0, exp_n: 8,   exp_first: 3, exp_done: 0};
    vecs[3] = '{stage: 9, mode: 0, inject: 0, exp_n: 512, exp_first: 3, exp_done: 515};
    vecs[4] = '{stage: 2, mode: 0, inject: 1, exp_n: 4,   exp_first: 3, exp_done: 7};
    vecs[5] = '{stage: 5, mode: 0, inject: 0, exp_n: 32,  exp_first: 3, exp_done: 35};

    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    reset_outputs("reset");
    iRESET = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start_stage(vecs[i].stage);
      collect(vecs[i].stage, vecs[i].mode, vecs[i].inject, vecs[i].exp_n,
              vecs[i].exp_first, vecs[i].exp_done, -1);
    end

    // Illegal stage: error pulse only, nothing else moves
    @(negedge iCLK);
    iREADY = 1'b1;
    addr_before = oROM_ADDR;
    start_stage(10);
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLK);
      check($sformatf("s10_err_c%0d", c),   64'(oERR),      64'(c == 0));
      check($sformatf("s10_busy_c%0d", c),  64'(oBUSY),     64'd0);
      check($sformatf("s10_valid_c%0d", c), 64'(oVALID),    64'd0);
      check($sformatf("s10_addr_c%0d", c),  64'(oROM_ADDR), 64'(addr_before));
    end
    $display("stage 10: rejected");

    // Back-to-back: next start lands in the oDONE cycle
    start_stage(1);
    collect(1, 0, 0, 2, 3, 5, 3);
    collect(3, 0, 0, 8, 3, 11, -1);

    // Reset in the middle of a stalled stage with both skid entries full
    start_stage(4);
    iREADY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge iCLK);
      iREADY = 1'b0;
    end
    check("midreset_valid_before", 64'(oVALID), 64'd1);
    check("midreset_head_k", 64'(oK), 64'd0);
    iRESET = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    reset_outputs("midreset");
    iRESET = 1'b1;
    $display("stage 4: reset mid-stage");
    start_stage(1);
    collect(1, 0, 0, 2, 3, 5, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
